// File: rtl/ysyx_24100012_pkg.sv
// Shared types and constants for the npc fetch path.
package ysyx_24100012_pkg;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    RESP    = 2'd1,
    OUT     = 2'd2,
    WAIT_WB = 2'd3
  } fetch_state_t;

  localparam logic [1:0]  RESP_OKAY           = 2'b00;
  localparam logic [31:0] INST_EBREAK         = 32'h00100073;
  localparam logic [31:0] DEFAULT_ORIGIN_ADDR = 32'h80000000;

  // A fetch address is legal only on a 4-byte boundary.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24100012_perf_cnt.sv
// Free-running enable counter with async active-low reset; wraps modulo 2^WIDTH.
module ysyx_24100012_perf_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // Count one per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_24100012_fetch_unit.sv
// Multi-cycle instruction fetch unit: one AXI4-Lite read per instruction,
// valid/ready hand-off to decode, then waits for write-back to commit the
// next PC. Optional performance counters under YSYX_24100012_FETCH_PERF_EN.
module ysyx_24100012_fetch_unit
  import ysyx_24100012_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  ORIGIN_ADDR = ADDR_WIDTH'(DEFAULT_ORIGIN_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_pc_next,
`ifdef YSYX_24100012_FETCH_PERF_EN
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_wait_cnt,
  output logic                  perf_proto_err,
`endif
  output logic                  fetch_fault
);

  fetch_state_t          r_state;
  fetch_state_t          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_inst_valid;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_fault;

  logic w_misaligned;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_rerr;

  assign w_misaligned = pc_misaligned(r_pc[1:0]);
  assign w_ar_hs      = (r_state == REQ) && r_arvalid && arready;
  assign w_r_hs       = (r_state == RESP) && r_rready && rvalid;
  assign w_rerr       = (rresp != RESP_OKAY);

  // Next-state and next-PC decode; rvalid only matters once the address is accepted.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      REQ: begin
        if (w_misaligned) begin
          w_state_next = OUT;
        end else if (w_ar_hs) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (w_r_hs) begin
          w_state_next = OUT;
        end
      end
      OUT: begin
        if (inst_ready) begin
          w_state_next = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (wb_valid) begin
          w_state_next = REQ;
          w_pc_next    = wb_pc_next;
        end
      end
      default: begin
        w_state_next = REQ;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake strobes registered from the next state; no request for a misaligned PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= ORIGIN_ADDR;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_inst_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_next;
      r_arvalid    <= (w_state_next == REQ) && !pc_misaligned(w_pc_next[1:0]);
      r_rready     <= (w_state_next == RESP);
      r_inst_valid <= (w_state_next == OUT);
    end
  end

  // Instruction capture; faults substitute ebreak so the core halts cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inst  <= '0;
      r_fault <= 1'b0;
    end else if ((r_state == REQ) && w_misaligned) begin
      r_inst  <= DATA_WIDTH'(INST_EBREAK);
      r_fault <= 1'b1;
    end else if (w_r_hs) begin
      if (w_rerr) begin
        r_inst  <= DATA_WIDTH'(INST_EBREAK);
        r_fault <= 1'b1;
      end else begin
        r_inst  <= rdata;
      end
    end
  end

  assign araddr      = r_pc;
  assign arvalid     = r_arvalid;
  assign rready      = r_rready;
  assign inst        = r_inst;
  assign pc          = r_pc;
  assign inst_valid  = r_inst_valid;
  assign fetch_fault = r_fault;

`ifdef YSYX_24100012_FETCH_PERF_EN
  logic w_wait;
  logic r_proto_err;

  assign w_wait = ((r_state == REQ) && r_arvalid && !arready) ||
                  ((r_state == RESP) && !rvalid);

  ysyx_24100012_perf_cnt #(.WIDTH(32)) u_fetch_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_r_hs),
    .o_cnt (perf_fetch_cnt)
  );

  ysyx_24100012_perf_cnt #(.WIDTH(32)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_wait),
    .o_cnt (perf_wait_cnt)
  );

  // Sticky flag for a commit strobe arriving while nothing is awaiting it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_proto_err <= 1'b0;
    end else if (wb_valid && (r_state != WAIT_WB)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign perf_proto_err = r_proto_err;
`endif

endmodule

// File: tb/tb_ysyx_24100012_fetch_unit.sv
// Self-checking bench for ysyx_24100012_fetch_unit (default build).
module tb_ysyx_24100012_fetch_unit;

  localparam logic [31:0] ORIGIN = 32'h80000000;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        wb_valid;
  logic [31:0] wb_pc_next;
  logic        fetch_fault;

  int n_tests;
  int n_fail;

  // Reference model state: architectural PC and sticky fault.
  logic [31:0] exp_pc;
  logic        exp_fault;

  ysyx_24100012_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .inst        (inst),
    .pc          (pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .wb_valid    (wb_valid),
    .wb_pc_next  (wb_pc_next),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete instruction loop; entered with the unit about to be in REQ.
  task automatic do_fetch(input logic [31:0] data, input logic [1:0] resp,
                          input int ar_dly, input int r_dly, input int hold,
                          input int wb_dly, input logic [31:0] next_pc);
    logic [31:0] exp_inst;
    logic        mis;
    mis = (exp_pc[1:0] != 2'b00);
    @(negedge clk);
    wb_valid = 1'b0;
    if (mis) begin
      chk("mis_no_arvalid", 32'(arvalid), 0);
      chk("mis_not_valid_yet", 32'(inst_valid), 0);
      arready = 1'b1;
      @(negedge clk);
      arready   = 1'b0;
      exp_fault = 1'b1;
      exp_inst  = EBREAK;
      chk("mis_no_arvalid2", 32'(arvalid), 0);
    end else begin
      chk("arvalid_first_cycle", 32'(arvalid), 1);
      chk("araddr", araddr, exp_pc);
      for (int k = 0; k < ar_dly; k++) begin
        arready = 1'b0;
        rvalid  = 1'($urandom % 2);
        rdata   = $urandom;
        @(negedge clk);
        chk("ar_hold_arvalid", 32'(arvalid), 1);
        chk("ar_hold_araddr", araddr, exp_pc);
        chk("ar_hold_rready", 32'(rready), 0);
      end
      arready = 1'b1;
      rvalid  = 1'($urandom % 2);
      rdata   = $urandom;
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b0;
      chk("resp_rready", 32'(rready), 1);
      chk("resp_arvalid_low", 32'(arvalid), 0);
      chk("resp_not_valid", 32'(inst_valid), 0);
      for (int k = 0; k < r_dly; k++) begin
        @(negedge clk);
        chk("r_wait_rready", 32'(rready), 1);
        chk("r_wait_not_valid", 32'(inst_valid), 0);
      end
      rvalid = 1'b1;
      rdata  = data;
      rresp  = resp;
      @(negedge clk);
      rvalid = 1'b0;
      rresp  = 2'b00;
      rdata  = $urandom;
      if (resp != 2'b00) exp_fault = 1'b1;
      exp_inst = (resp == 2'b00) ? data : EBREAK;
    end
    chk("out_inst_valid", 32'(inst_valid), 1);
    chk("out_inst", inst, exp_inst);
    chk("out_pc", pc, exp_pc);
    chk("out_fault", 32'(fetch_fault), 32'(exp_fault));
    chk("out_rready_low", 32'(rready), 0);
    chk("out_arvalid_low", 32'(arvalid), 0);
    // Decode stalls; stray commit strobes and read data must be ignored.
    for (int k = 0; k < hold; k++) begin
      inst_ready = 1'b0;
      wb_valid   = ($urandom % 3 == 0);
      wb_pc_next = $urandom;
      rvalid     = 1'($urandom % 2);
      rdata      = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(inst_valid), 1);
      chk("hold_inst", inst, exp_inst);
      chk("hold_pc", pc, exp_pc);
      chk("hold_no_ar", 32'(arvalid), 0);
    end
    wb_valid   = 1'b0;
    rvalid     = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    chk("accepted_valid_low", 32'(inst_valid), 0);
    for (int k = 0; k < wb_dly; k++) begin
      rvalid = 1'($urandom % 2);
      rdata  = $urandom;
      @(negedge clk);
      chk("wb_wait_no_ar", 32'(arvalid), 0);
      chk("wb_wait_no_rready", 32'(rready), 0);
      chk("wb_wait_inst", inst, exp_inst);
    end
    rvalid     = 1'b0;
    wb_valid   = 1'b1;
    wb_pc_next = next_pc;
    exp_pc     = next_pc;
  endtask

  initial begin
    logic [31:0] nxt;
    logic [1:0]  rsp;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b0;
    arready    = 1'b0;
    rdata      = '0;
    rresp      = 2'b00;
    rvalid     = 1'b0;
    inst_ready = 1'b0;
    wb_valid   = 1'b0;
    wb_pc_next = '0;
    exp_pc     = ORIGIN;
    exp_fault  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_pc", pc, ORIGIN);
    chk("rst_inst", inst, 0);
    rst = 1'b1;

    // Zero-wait slave, decode stalls 5 cycles, then sequential PC.
    do_fetch(32'h00000413, 2'b00, 0, 0, 5, 1, 32'h80000004);
    // Slow address acceptance.
    do_fetch(32'h00a00093, 2'b00, 3, 2, 0, 0, 32'h80000008);
    // Bus error.
    do_fetch(32'hdeadbeef, 2'b10, 1, 0, 1, 2, 32'h80000102);
    // Misaligned target: no request, ebreak delivered.
    do_fetch(32'h0, 2'b00, 0, 0, 2, 1, 32'h80000200);
    do_fetch(32'h12345678, 2'b00, 0, 1, 0, 0, 32'h80000204);

    // Randomised loops against the model.
    for (int i = 0; i < 24; i++) begin
      nxt = ORIGIN + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom % 6 == 0) nxt = nxt + 32'($urandom_range(1, 3));
      rsp = ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_fetch($urandom, rsp, $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 2), nxt);
    end
    // Make sure the next fetch is aligned before the reset test.
    do_fetch($urandom, 2'b00, 0, 0, 0, 0, 32'h80000010);

    // Reset while waiting for read data.
    @(negedge clk);
    wb_valid = 1'b0;
    chk("prerst_arvalid", 32'(arvalid), 1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("prerst_rready", 32'(rready), 1);
    rst = 1'b0;
    #1;
    chk("midrst_pc", pc, ORIGIN);
    chk("midrst_inst_valid", 32'(inst_valid), 0);
    chk("midrst_rready", 32'(rready), 0);
    chk("midrst_fault", 32'(fetch_fault), 0);
    chk("midrst_arvalid", 32'(arvalid), 0);
    @(negedge clk);
    rst       = 1'b1;
    exp_pc    = ORIGIN;
    exp_fault = 1'b0;
    do_fetch(32'h00000513, 2'b00, 0, 0, 0, 0, 32'h80000004);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("restart_arvalid", 32'(arvalid), 1);
    chk("restart_araddr", araddr, 32'h80000004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_fetch_unit.md
# ysyx_24100012_fetch_unit

Multi-cycle instruction fetch unit for the npc core, replacing the single-cycle PC register/combinational IMem path. It holds the PC, issues one AXI4-Lite read per instruction, and delivers the fetched word to the decode stage over a valid/ready handshake. It then waits for the write-back stage to commit the next PC before fetching again, so exactly one instruction is in flight.

## Interface
- ADDR_WIDTH, 32, address/PC width
- DATA_WIDTH, 32, instruction/bus data width
- ORIGIN_ADDR, 32'h80000000, PC value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- araddr  out  ADDR_WIDTH  read address (always equals pc)
- arvalid  out  1  read request valid
- arready  in  1  slave accepts request
- rdata  in  DATA_WIDTH  read data
- rresp  in  2  read response; 2'b00 OKAY, anything else is an error
- rvalid  in  1  read data valid
- rready  out  1  master accepts data
- inst  out  DATA_WIDTH  registered instruction to decode
- pc  out  ADDR_WIDTH  PC of inst
- inst_valid  out  1  inst/pc valid to decode
- inst_ready  in  1  decode accepts inst
- wb_valid  in  1  write-back commit strobe, one cycle
- wb_pc_next  in  ADDR_WIDTH  next PC from write-back (PC+4 or branch/jump target)
- fetch_fault  out  1  sticky: misaligned PC or bus error seen

## Operation
- States: REQ, RESP, OUT, WAIT_WB.
- REQ: arvalid=1, araddr=pc. On arvalid&&arready, go to RESP. If pc[1:0]!=0, issue no request; set fetch_fault, load inst=32'h00100073 (ebreak, halts the core), and go to OUT.
- RESP: rready=1. On rvalid, latch inst=rdata and go to OUT. If rresp!=0, also set fetch_fault and force inst=32'h00100073.
- OUT: inst_valid=1; inst and pc held stable. On inst_ready, go to WAIT_WB.
- WAIT_WB: on wb_valid, pc<=wb_pc_next and go to REQ. wb_valid in any other state is ignored and counted as a protocol error; it does not change pc.
- The slave must not assert rvalid before the address handshake. The unit ignores rvalid outside RESP.
- arvalid, once asserted, stays high with araddr stable until arready, per AXI.
- fetch_fault clears only on reset.

## Timing
- Reset values: state=REQ, pc=ORIGIN_ADDR, inst=0, inst_valid=0, arvalid=0 in the cycle reset is asserted, rready=0, fetch_fault=0.
- arvalid is driven from state (registered decode). First request: arvalid=1 in the first cycle after rst deasserts.
- Minimum latency with zero-wait slave: request cycle N, rdata accepted N+1, inst_valid=1 from N+2.
- With immediate inst_ready and wb_valid, the loop takes 4 cycles per instruction minimum.
- Reset mid-transaction: state returns to REQ immediately. Outstanding bus responses after reset are the slave's responsibility (the SoC resets both together).
- arready and rvalid in the same cycle while in REQ: only the address handshake is taken; rvalid is sampled from the next cycle.

## Configuration
- YSYX_24100012_FETCH_PERF_EN defined:
  - Adds output ports perf_fetch_cnt[31:0], the number of completed R handshakes.
  - Adds output ports perf_wait_cnt[31:0], the number of cycles spent in REQ or RESP without a handshake.
  - Adds output port perf_proto_err, sticky; set by wb_valid outside WAIT_WB.
  - All counters reset to 0 and wrap modulo 2^32.
- Not defined: these ports and their logic are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package ysyx_24100012_pkg holds:
  - fetch_state_t enum (REQ, RESP, OUT, WAIT_WB)
  - RESP_OKAY = 2'b00
  - INST_EBREAK = 32'h00100073
  - default ORIGIN_ADDR
- One sub-module, ysyx_24100012_perf_cnt: a parameterized 32-bit enable counter with async active-low reset. It is instantiated twice, only under the macro.

## Test plan
- Reset release, slave with arready=1 and rvalid one cycle later with rdata=32'h00000413 -> araddr=32'h80000000; inst_valid at cycle 3; inst=32'h00000413, pc=32'h80000000.
- Decode holds inst_ready=0 for 5 cycles -> inst and pc stable, no new arvalid. Then wb_valid with wb_pc_next=32'h80000004 -> next araddr=32'h80000004.
- arready delayed 3 cycles -> arvalid and araddr stable throughout. With PERF_EN, perf_wait_cnt=3 after the handshake.
- rresp=2'b10 -> fetch_fault=1, inst=32'h00100073, inst_valid=1.
- wb_pc_next=32'h80000102 -> no AR request issued; fetch_fault=1, inst=32'h00100073.
- rst pulled low while in RESP -> next cycle pc=32'h80000000, inst_valid=0, rready=0, fetch_fault=0. Fetch restarts after release.
